// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot-time byte-stream loader for instruction memory; LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
module instr_mem_loader #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        CHECK  = 3'd5,
`endif
        DONE   = 3'd6,
        ERR    = 3'd7
    } state_t;

    state_t      state;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        accept;
    logic [15:0] len_next;

    // A byte moves only when the registered ready meets the source's valid.
    assign accept   = s_valid & s_ready;
    assign len_next = {len[15:8], s_data};

    // Loader FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            len      <= 16'd0;
            word_idx <= 16'd0;
            byte_idx <= 2'd0;
            word_q   <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= 8'd0;
`endif
            s_ready  <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= 32'd0;
            im_wdata <= 32'd0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state    <= LEN_HI;
                        word_idx <= 16'd0;
                        byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= 8'd0;
`endif
                        s_ready  <= 1'b1;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= s_data;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= csum ^ s_data;
`endif
                        state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= s_data;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ s_data;
`endif
                        if ({1'b0, len_next} > 17'(DEPTH_WORDS)) begin
                            state   <= ERR;
                            s_ready <= 1'b0;
                            busy    <= 1'b0;
                            error   <= 1'b1;
                        end else if (len_next == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= CHECK;
`else
                            state    <= DONE;
                            s_ready  <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                        csum     <= csum ^ s_data;
`endif
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_q[7:0]   <= s_data;
                            2'd1: word_q[15:8]  <= s_data;
                            2'd2: word_q[23:16] <= s_data;
                            default: begin
                                // Last byte goes straight into the write data; no extra cycle.
                                state    <= WRITE;
                                s_ready  <= 1'b0;
                                im_we    <= 1'b1;
                                im_addr  <= {14'd0, word_idx, 2'b00};
                                im_wdata <= {s_data, word_q};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    if (word_idx == len - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state    <= CHECK;
                        s_ready  <= 1'b1;
`else
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
`endif
                    end else begin
                        state   <= DATA;
                        s_ready <= 1'b1;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        s_ready <= 1'b0;
                        busy    <= 1'b0;
                        if (s_data == csum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    s_ready <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - table-driven self-checking bench for instr_mem_loader
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;

    int          wr_count = 0;
    logic [31:0] cap_addr [0:2047];
    logic [31:0] cap_data [0:2047];

    always #5 clk = ~clk;

    instr_mem_loader #(.DEPTH_WORDS(256)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    // Capture every memory write away from the rising edge.
    always @(negedge clk) begin
        if (im_we) begin
            if (wr_count < 2048) begin
                cap_addr[wr_count] = im_addr;
                cap_data[wr_count] = im_wdata;
            end
            wr_count++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] n;
        logic [31:0] seed;
        int          gap;
        bit          bad_csum;
        bit          exp_done;
        int          exp_writes;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] seed, input int i);
        return seed ^ (32'(i) * 32'h9E3779B1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g;
        bit ok;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        s_valid = 1'b0;
        repeat (g) step();
        s_valid = 1'b1;
        s_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL s_ready_timeout: byte 0x%0h not accepted within 100 cycles", b);
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic run_load(input int r, input vec_t v);
        int          base;
        logic [7:0]  cs;
        logic [31:0] w;
        base = wr_count;
        cs   = 8'h00;
        pulse_start();
        check($sformatf("row%0d_busy_after_start", r), 32'(busy), 32'd1);
        check($sformatf("row%0d_hold_after_start", r), 32'(cpu_hold), 32'd1);
        check($sformatf("row%0d_done_cleared", r), 32'({done, error}), 32'd0);
        send_byte(v.n[15:8], v.gap);
        cs ^= v.n[15:8];
        send_byte(v.n[7:0], v.gap);
        cs ^= v.n[7:0];
        if (v.n <= 16'd256) begin
            for (int i = 0; i < int'(v.n); i++) begin
                w = word_of(v.seed, i);
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8], v.gap);
                    cs ^= w[8*k +: 8];
                end
                if (i < 4 || i == int'(v.n) - 1) begin
                    check($sformatf("row%0d_we_latency_w%0d", r, i), 32'(im_we), 32'd1);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(v.bad_csum ? (cs ^ 8'hF6) : cs, v.gap);
`endif
        end
        repeat (3) step();
        check($sformatf("row%0d_done", r), 32'(done), 32'(v.exp_done));
        check($sformatf("row%0d_error", r), 32'(error), 32'(!v.exp_done));
        check($sformatf("row%0d_cpu_hold", r), 32'(cpu_hold), 32'(!v.exp_done));
        check($sformatf("row%0d_busy", r), 32'(busy), 32'd0);
        check($sformatf("row%0d_s_ready", r), 32'(s_ready), 32'd0);
        check($sformatf("row%0d_writes", r), 32'(wr_count - base), 32'(v.exp_writes));
        for (int i = 0; i < v.exp_writes && i < wr_count - base; i++) begin
            check($sformatf("row%0d_addr%0d", r, i), cap_addr[base + i], 32'(i) << 2);
            check($sformatf("row%0d_data%0d", r, i), cap_data[base + i], word_of(v.seed, i));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"},  32'(s_ready),  32'd0);
        check({tag, "_im_we"},    32'(im_we),    32'd0);
        check({tag, "_im_addr"},  im_addr,       32'd0);
        check({tag, "_im_wdata"}, im_wdata,      32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_error"},    32'(error),    32'd0);
    endtask

    initial begin
        int   base;
        vec_t v;
        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;

        step();
        check_reset_values("por");
        reset = 1'b1;
        step();

        // Bytes offered in IDLE must not be taken.
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (3) step();
        check("idle_s_ready_low", 32'(s_ready), 32'd0);
        check("idle_hold", 32'(cpu_hold), 32'd1);
        s_valid = 1'b0;

        //            n         seed           gap bad exp_done writes
        vecs.push_back('{16'h0001, 32'h12345678, 0, 1'b0, 1'b1, 1});
        vecs.push_back('{16'h0003, 32'hCAFEF00D, 3, 1'b0, 1'b1, 3});
        vecs.push_back('{16'h0000, 32'h00000000, 0, 1'b0, 1'b1, 0});
        vecs.push_back('{16'h0101, 32'h00000000, 0, 1'b0, 1'b0, 0});
        vecs.push_back('{16'h0100, 32'hA5A55A5A, 0, 1'b0, 1'b1, 256});
        vecs.push_back('{16'h8000, 32'h00000000, 1, 1'b0, 1'b0, 0});
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back('{16'h0001, 32'h12345678, 0, 1'b1, 1'b0, 1});
`endif
        vecs.push_back('{16'h0002, 32'h0BADBEEF, 2, 1'b0, 1'b1, 2});

        foreach (vecs[r]) run_load(r, vecs[r]);

        // Reset mid-load after the second data byte.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        reset = 1'b0;
        #1;
        check_reset_values("midrst");
        step();
        reset = 1'b1;
        step();
        v = '{16'h0002, 32'h31415926, 1, 1'b0, 1'b1, 2};
        run_load(100, v);

        // start while busy is ignored.
        base = wr_count;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hEF, 0);
        send_byte(8'hBE, 0);
        pulse_start();
        check("busy_start_still_busy", 32'(busy), 32'd1);
        send_byte(8'hAD, 0);
        send_byte(8'hDE, 0);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h00 ^ 8'h01 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE, 0);
`endif
        repeat (3) step();
        check("busy_start_done", 32'(done), 32'd1);
        check("busy_start_writes", 32'(wr_count - base), 32'd1);
        check("busy_start_addr", cap_addr[base], 32'd0);
        check("busy_start_data", cap_data[base], 32'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
